ahb_arbiter_param: RTL and testbench
====================================

# ahb_arbiter_param

Parametrised AHB bus arbiter and the next-generation replacement of the fixed 16-master arbiter. It supports 2 to 16 masters and two arbitration modes: fixed priority or round-robin. It adds a burst-hold cap, a SPLIT mask driven by slave responses, and a default-master fallback. It sits between the master request/lock lines and the address/control multiplexer, and drives HGRANTx, HMASTER and HMASTLOCK.

## Interface
- NUM_MASTERS, 16, number of masters (2..16); master index i maps to bit i.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- DEFAULT_MASTER, 0, master granted when nobody is eligible (must be < NUM_MASTERS).
- MAX_HOLD, 16, maximum transfers the owner may perform before forced re-arbitration (1..255); 0 = unlimited.

Ports:
- HCLK  in  1  bus clock; all state changes on the rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HBUSREQx  in  NUM_MASTERS  bus request per master.
- HLOCKx  in  NUM_MASTERS  locked-transfer request per master.
- HSPLIT  in  NUM_MASTERS  slave split-resume; bit i clears the split mask for master i.
- HREADY  in  1  transfer done / bus handover enable.
- HTRANS  in  2  transfer type of the current address phase (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HRESP  in  2  slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11).
- HGRANTx  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  4  index of the master owning the address phase, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

## Operation
- Eligible vector: E = HBUSREQx & ~split_mask.
- Arbitration evaluates every cycle. Results load only on an edge with HREADY=1.
- Re-arbitration is allowed unless the owner holds the bus:
  - Owner holds when its HBUSREQx bit and its HLOCKx bit are both high. A locked owner is never preempted and the hold cap is ignored.
  - Owner also holds when its HBUSREQx bit is high and MAX_HOLD=0, or when hold_cnt < MAX_HOLD.
- Winner selection:
  - ARB_MODE=0: lowest set bit of E.
  - ARB_MODE=1: first set bit of E searching upward from rr_ptr+1, wrapping at NUM_MASTERS-1 back to 0.
  - E==0: DEFAULT_MASTER is granted, even if its bit is split-masked.
- Cap expiry: when hold_cnt==MAX_HOLD, the owner's bit is removed from E before selection if any other bit of E is set. Otherwise the owner is re-granted and hold_cnt restarts.
- hold_cnt (8 bit):
  - Increments on HREADY=1 with HTRANS = NONSEQ or SEQ while HMASTER equals the granted index.
  - Resets to 0 on every grant change and on re-grant after expiry.
  - Saturates at MAX_HOLD.
- rr_ptr updates to the new winner index on each grant load. Grants to DEFAULT_MASTER caused by E==0 do not move rr_ptr.
- HMASTER loads the index of HGRANTx on each HREADY=1 edge, i.e. the previous grant becomes the address-phase owner.
- HMASTLOCK loads HLOCKx[granted index] on the same edge.
- Split mask:
  - Set: bit HMASTER is set on an edge with HREADY=1 and HRESP=SPLIT (second cycle of the SPLIT response).
  - Clear: bit i is cleared on any edge where HSPLIT[i]=1.
  - Simultaneous set and clear of the same bit: clear wins.
- HSPLIT and HBUSREQx bits at or above NUM_MASTERS are absent. HMASTER upper bits are zero.

## Timing
- Reset values:
  - HGRANTx = one-hot DEFAULT_MASTER.
  - HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - split_mask = 0, hold_cnt = 0, rr_ptr = DEFAULT_MASTER.
- Reset asserted mid-transfer forces these values on the next edge, regardless of HREADY.
- Request-to-grant latency: 1 edge with HREADY=1 (request sampled at cycle n, HGRANTx valid at n+1 if HREADY=1 at n).
- Grant-to-HMASTER latency: 1 further edge with HREADY=1.
- HREADY=0 freezes HGRANTx, HMASTER, HMASTLOCK, hold_cnt and rr_ptr. The split mask clear via HSPLIT still occurs.
- $countones(HGRANTx)==1 at all times after reset.
- A request withdrawn before an HREADY=1 edge is never granted. No grant is produced from stale requests.

## Test plan
- Fixed priority (ARB_MODE=0): HBUSREQx=0x0006, HREADY=1 -> HGRANTx=0x0002 after 1 edge; HMASTER=1 one edge later.
- Round-robin (ARB_MODE=1, NUM_MASTERS=4): HBUSREQx=0xF held with HTRANS=NONSEQ, MAX_HOLD=1 -> grant sequence 1,2,3,0,1 from reset (rr_ptr=0).
- Hold cap (MAX_HOLD=4): master 0 bursts SEQ continuously with master 2 requesting -> grant moves to master 2 after exactly 4 counted transfers. With HLOCKx[0]=1, the grant stays at 0 indefinitely and HMASTLOCK=1.
- Split: master 3 owns the bus and receives HRESP=SPLIT with HREADY=1 -> master 3 not granted despite HBUSREQx[3]=1. HSPLIT[3] pulse -> master 3 regranted on the next arbitration.
- Idle bus: HBUSREQx=0 -> HGRANTx=one-hot DEFAULT_MASTER, rr_ptr unchanged. DEFAULT_MASTER split-masked -> still granted.
- Stall and reset: HREADY=0 for 5 cycles while requests change -> outputs frozen. HRESET=1 mid-burst -> reset values on the next edge, hold_cnt=0.

Source files
------------

// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB bus arbiter: fixed-priority or round-robin selection with a
// burst-hold cap, a SPLIT mask driven by slave responses and a default-master fallback.
module ahb_arbiter_param #(
    parameter int NUM_MASTERS    = 16,
    parameter int ARB_MODE       = 0,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [3:0]             HMASTER,
    output logic                   HMASTLOCK
);

    typedef logic [3:0]             idx_t;
    typedef logic [NUM_MASTERS-1:0] vec_t;

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_SPLIT   = 2'b11;
    localparam idx_t       DEF_IDX      = idx_t'(DEFAULT_MASTER);
    // An unlimited hold still needs a ceiling for the 8-bit counter to saturate at.
    localparam logic [7:0] HOLD_CAP     = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);

    function automatic vec_t onehot(input idx_t idx);
        vec_t v;
        for (int k = 0; k < NUM_MASTERS; k++) v[k] = (idx == idx_t'(k));
        return v;
    endfunction

    function automatic idx_t lowest_set(input vec_t v);
        idx_t r;
        r = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) if (v[k]) r = idx_t'(k);
        return r;
    endfunction

    vec_t       split_mask;
    idx_t       grant_idx;
    idx_t       rr_ptr;
    logic [7:0] hold_cnt;

    vec_t       eligible;
    vec_t       cand;
    vec_t       rot;
    vec_t       split_set;
    vec_t       split_next;
    idx_t       start;
    idx_t       off;
    idx_t       next_idx;
    logic [4:0] sum;
    logic       owner_elig;
    logic       owner_lock;
    logic       holds;
    logic       expired;
    logic       from_default;
    logic       count_beat;
    logic [7:0] hold_next;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
        eligible   = HBUSREQx & ~split_mask;
        owner_elig = |(eligible & HGRANTx);
        owner_lock = |(HLOCKx & HGRANTx);
        expired    = (MAX_HOLD != 0) && (hold_cnt == HOLD_CAP);
        holds      = owner_elig && (owner_lock || MAX_HOLD == 0 || hold_cnt < HOLD_CAP);

        cand = eligible;
        if (expired && |(eligible & ~HGRANTx)) cand = eligible & ~HGRANTx;

        // Rotate so the search starts just above rr_ptr, then map the offset back.
        start = (rr_ptr == idx_t'(NUM_MASTERS - 1)) ? '0 : rr_ptr + 1'b1;
        rot   = (cand >> start) | (cand << (NUM_MASTERS - int'(start)));
        off   = lowest_set(rot);
        sum   = {1'b0, start} + {1'b0, off};
        if (sum >= 5'(NUM_MASTERS)) sum = sum - 5'(NUM_MASTERS);

        from_default = 1'b0;
        if (holds) begin
            next_idx = grant_idx;
        end else if (cand == '0) begin
            next_idx     = DEF_IDX;
            from_default = 1'b1;
        end else if (ARB_MODE == 1) begin
            next_idx = sum[3:0];
        end else begin
            next_idx = lowest_set(cand);
        end

        count_beat = (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ) && (HMASTER == grant_idx);
        hold_next  = '0;
        if (holds) hold_next = (count_beat && hold_cnt != HOLD_CAP) ? hold_cnt + 8'd1 : hold_cnt;

        split_set  = (HREADY && HRESP == RESP_SPLIT) ? onehot(HMASTER) : '0;
        split_next = (split_mask | split_set) & ~HSPLIT;
    end

    always_ff @(posedge HCLK) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge state.
        if (HRESET) begin
            HGRANTx    <= onehot(DEF_IDX);
            grant_idx  <= DEF_IDX;
            HMASTER    <= DEF_IDX;
            HMASTLOCK  <= 1'b0;
            split_mask <= '0;
            hold_cnt   <= '0;
            rr_ptr     <= DEF_IDX;
        end else begin
            split_mask <= split_next;
            if (HREADY) begin
                HGRANTx   <= onehot(next_idx);
                grant_idx <= next_idx;
                HMASTER   <= grant_idx;
                HMASTLOCK <= owner_lock;
                hold_cnt  <= hold_next;
                if (!from_default) rr_ptr <= next_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Scoreboard bench for ahb_arbiter_param: a 16-master fixed-priority instance and a
// 4-master round-robin instance share stimulus and are checked against a reference model.
module tb_ahb_arbiter_param;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SPLIT  = 2'b11;

    typedef struct {
        int n;
        int mode;
        int dflt;
        int maxh;
    } mcfg_t;

    typedef struct {
        int grant;
        int master;
        bit lock;
        int split;
        int cnt;
        int rr;
    } mstate_t;

    typedef struct {
        int    fp_grant;
        int    fp_master;
        bit    fp_lock;
        int    rr_grant;
        int    rr_master;
        bit    rr_lock;
        int    dir_fp;
        int    dir_rr;
        string tag;
    } exp_t;

    logic        HCLK;
    logic        rst;
    logic [15:0] req;
    logic [15:0] lck;
    logic [15:0] spl;
    logic        rdy;
    logic [1:0]  trn;
    logic [1:0]  rsp;

    logic [15:0] fp_grant;
    logic [3:0]  fp_master;
    logic        fp_lock;
    logic [3:0]  rr_grant;
    logic [3:0]  rr_master;
    logic        rr_lock;

    int      n_checks = 0;
    int      n_errors = 0;
    exp_t    sbq[$];
    mcfg_t   cfg_fp;
    mcfg_t   cfg_rr;
    mstate_t s_fp;
    mstate_t s_rr;

    ahb_arbiter_param #(
        .NUM_MASTERS(16), .ARB_MODE(0), .DEFAULT_MASTER(5), .MAX_HOLD(4)
    ) u_fp (
        .HCLK(HCLK), .HRESET(rst), .HBUSREQx(req), .HLOCKx(lck), .HSPLIT(spl),
        .HREADY(rdy), .HTRANS(trn), .HRESP(rsp),
        .HGRANTx(fp_grant), .HMASTER(fp_master), .HMASTLOCK(fp_lock)
    );

    ahb_arbiter_param #(
        .NUM_MASTERS(4), .ARB_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(1)
    ) u_rr (
        .HCLK(HCLK), .HRESET(rst), .HBUSREQx(req[3:0]), .HLOCKx(lck[3:0]), .HSPLIT(spl[3:0]),
        .HREADY(rdy), .HTRANS(trn), .HRESP(rsp),
        .HGRANTx(rr_grant), .HMASTER(rr_master), .HMASTLOCK(rr_lock)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Next bus state after one clock edge, derived from the arbitration rules.
    function automatic mstate_t ref_next(input mstate_t s, input mcfg_t c, input bit r,
                                         input int rq, input int lk, input int sp,
                                         input bit hr, input int tr, input int rs);
        mstate_t t;
        int  all;
        int  elig;
        int  cand;
        int  win;
        int  cap;
        int  j;
        bit  holds;
        bit  via_default;
        t = s;
        all = (1 << c.n) - 1;
        if (r) begin
            t.grant = c.dflt; t.master = c.dflt; t.lock = 1'b0;
            t.split = 0; t.cnt = 0; t.rr = c.dflt;
            return t;
        end
        if (!hr) begin
            t.split = s.split & ~sp & all;
            return t;
        end
        elig = rq & ~s.split & all;
        cap = (c.maxh == 0) ? 255 : c.maxh;
        holds = (((elig >> s.grant) & 1) != 0) &&
                ((((lk >> s.grant) & 1) != 0) || c.maxh == 0 || s.cnt < cap);
        via_default = 1'b0;
        win = s.grant;
        if (!holds) begin
            cand = elig;
            if (c.maxh != 0 && s.cnt == cap && (elig & ~(1 << s.grant)) != 0)
                cand = elig & ~(1 << s.grant);
            if (cand == 0) begin
                win = c.dflt;
                via_default = 1'b1;
            end else if (c.mode == 0) begin
                for (int i = c.n - 1; i >= 0; i--) if (((cand >> i) & 1) != 0) win = i;
            end else begin
                win = -1;
                for (int k = 1; k <= c.n; k++) begin
                    j = (s.rr + k) % c.n;
                    if (win < 0 && ((cand >> j) & 1) != 0) win = j;
                end
            end
        end
        if (win != s.grant || !holds) t.cnt = 0;
        else if ((tr == 2 || tr == 3) && s.master == s.grant && s.cnt < cap) t.cnt = s.cnt + 1;
        if (!via_default) t.rr = win;
        t.master = s.grant;
        t.lock   = ((lk >> s.grant) & 1) != 0;
        t.grant  = win;
        t.split  = (s.split | ((rs == 3) ? (1 << s.master) : 0)) & ~sp & all;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setin(input logic r, input logic [15:0] q, input logic [15:0] l,
                         input logic [15:0] s, input logic h, input logic [1:0] t,
                         input logic [1:0] p);
        rst = r; req = q; lck = l; spl = s; rdy = h; trn = t; rsp = p;
    endtask

    // Apply the current inputs for one edge and queue what both instances must show after it.
    task automatic step(input string tag, input int dfp, input int drr);
        exp_t e;
        s_fp = ref_next(s_fp, cfg_fp, rst, int'(req), int'(lck), int'(spl), rdy, int'(trn), int'(rsp));
        s_rr = ref_next(s_rr, cfg_rr, rst, int'(req), int'(lck), int'(spl), rdy, int'(trn), int'(rsp));
        e.fp_grant  = s_fp.grant;
        e.fp_master = s_fp.master;
        e.fp_lock   = s_fp.lock;
        e.rr_grant  = s_rr.grant;
        e.rr_master = s_rr.master;
        e.rr_lock   = s_rr.lock;
        e.dir_fp    = dfp;
        e.dir_rr    = drr;
        e.tag       = tag;
        sbq.push_back(e);
        @(negedge HCLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge HCLK);
            #2;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check({e.tag, "/fp_grant"},  32'(fp_grant),  32'(1 << e.fp_grant));
                check({e.tag, "/fp_master"}, 32'(fp_master), 32'(e.fp_master));
                check({e.tag, "/fp_lock"},   32'(fp_lock),   32'(e.fp_lock));
                check({e.tag, "/fp_onehot"}, 32'($countones(fp_grant)), 32'd1);
                check({e.tag, "/rr_grant"},  32'(rr_grant),  32'(1 << e.rr_grant));
                check({e.tag, "/rr_master"}, 32'(rr_master), 32'(e.rr_master));
                check({e.tag, "/rr_lock"},   32'(rr_lock),   32'(e.rr_lock));
                check({e.tag, "/rr_onehot"}, 32'($countones(rr_grant)), 32'd1);
                if (e.dir_fp >= 0) check({e.tag, "/fp_directed"}, 32'(fp_grant), 32'(1 << e.dir_fp));
                if (e.dir_rr >= 0) check({e.tag, "/rr_directed"}, 32'(rr_grant), 32'(1 << e.dir_rr));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int rr_seq[14] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
        int guard;
        cfg_fp = '{n: 16, mode: 0, dflt: 5, maxh: 4};
        cfg_rr = '{n: 4,  mode: 1, dflt: 0, maxh: 1};
        s_fp = '{default: 0};
        s_rr = '{default: 0};
        #1;

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        step("reset", 5, 0);

        setin(0, 16'h0006, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("fp_prio", 1, 1);
        step("fp_prio_hold", 1, -1);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h000F, 16'h0, 16'h0, 1, NONSEQ, OKAY);
        for (int i = 0; i < 14; i++) step("rr_seq", -1, rr_seq[i]);
        setin(0, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        repeat (3) step("idle_default", 5, 0);
        setin(0, 16'h000A, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("rr_ptr_kept", 1, 3);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h0005, 16'h0, 16'h0, 1, SEQ, OKAY);
        repeat (6) step("hold_cap", 0, -1);
        step("hold_cap_expire", 2, -1);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h0005, 16'h0001, 16'h0, 1, SEQ, OKAY);
        repeat (12) step("lock_hold", 0, -1);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h0008, 16'h0, 16'h0, 1, NONSEQ, OKAY);
        step("split_own", 3, -1);
        step("split_own", 3, -1);
        setin(0, 16'h0008, 16'h0, 16'h0, 1, NONSEQ, SPLIT);
        step("split_resp", 3, -1);
        setin(0, 16'h0008, 16'h0, 16'h0, 1, NONSEQ, OKAY);
        step("split_masked", 5, -1);
        step("split_masked", 5, -1);
        setin(0, 16'h0008, 16'h0, 16'h0008, 1, NONSEQ, OKAY);
        step("split_resume_edge", 5, -1);
        setin(0, 16'h0008, 16'h0, 16'h0, 1, NONSEQ, OKAY);
        step("split_regrant", 3, -1);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h0000, 16'h0, 16'h0, 1, IDLE, SPLIT);
        step("dflt_split_set", 5, 0);
        setin(0, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("dflt_masked", 5, 0);
        setin(0, 16'h0020, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("dflt_masked_req", 5, -1);

        setin(1, 16'h0000, 16'h0, 16'h0, 1, IDLE, OKAY);
        step("reset", 5, 0);
        setin(0, 16'h0002, 16'h0, 16'h0, 1, NONSEQ, OKAY);
        step("stall_pre", 1, 1);
        for (int i = 0; i < 5; i++) begin
            setin(0, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'($urandom_range(0, 3)), SPLIT);
            step("stall", 1, 1);
        end
        setin(0, 16'h0002, 16'h0, 16'h0, 1, SEQ, OKAY);
        step("burst", 1, 1);
        step("burst", 1, 1);
        setin(1, 16'h0002, 16'h0, 16'h0, 0, SEQ, OKAY);
        step("mid_reset", 5, 0);
        setin(0, 16'h0006, 16'h0, 16'h0, 1, SEQ, OKAY);
        repeat (8) step("post_reset_burst", -1, -1);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            req = 16'($urandom);
            if ($urandom_range(0, 2) == 0) req = req & 16'($urandom);
            lck = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            spl = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h0;
            rdy = ($urandom_range(0, 4) != 0);
            trn = 2'($urandom_range(0, 3));
            rsp = ($urandom_range(0, 9) == 0) ? SPLIT : 2'($urandom_range(0, 2));
            step("random", -1, -1);
        end

        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(posedge HCLK);
            guard++;
        end
        #3;
        check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
